spi_ctrl: RTL and testbench

SPI_CTRL -- requirements
Module: spi_ctrl

---
 rtl/spi_ctrl_pkg.sv | 24 ++
 rtl/spi_shift_reg.sv | 76 +++++++
 rtl/spi_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI-to-Wishbone bridge.
// Frames are a command byte {rw, addr[6:0]} followed by one data byte.
package spi_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    WR_REQ  = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Wishbone address carried by a command byte; the top address bit is always 0.
  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [DATA_W-1:0] cmd);
    return {1'b0, cmd[CMD_RW_BIT-1:0]};
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Byte shifter for the SPI slave: MOSI shifts in on SCK fall, MISO shifts out
// on SCK rise, and a one-cycle byte_ready pulse marks every 8th falling edge.
module spi_shift_reg
  import spi_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sck_rise,
  input  logic              sck_fall,
  input  logic              mosi,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              byte_ready
);

  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              miso_q, miso_d;
  logic              rdy_q, rdy_d;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    cnt_d  = cnt_q;
    miso_d = miso_q;
    rdy_d  = 1'b0;
    if (clr) begin
      rx_d   = '0;
      tx_d   = '0;
      cnt_d  = '0;
      miso_d = 1'b0;
    end else begin
      if (sck_fall) begin
        rx_d  = {rx_q[DATA_W-2:0], mosi};
        cnt_d = cnt_q + 3'd1;
        rdy_d = (cnt_q == 3'd7);
      end
      // The controller never requests a load in a cycle carrying a rising edge.
      if (load) begin
        tx_d = load_data;
      end else if (sck_rise) begin
        miso_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q   <= '0;
      tx_q   <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
      rdy_q  <= rdy_d;
    end
  end

  assign miso       = miso_q;
  assign rx_data    = rx_q;
  assign byte_ready = rdy_q;

endmodule

// File: rtl/spi_ctrl.sv
// SPI slave (CPOL=0) bridging two-byte frames onto a Wishbone master port.
// SPI pins are oversampled in the wb_clk_i domain through synchronizers.
module spi_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  input  logic              wb_ack_i
);

  // Synchronizer chain, one 3-bit lane per stage: {sck, ss, mosi}.
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = {spi_sck, spi_ss, spi_mosi};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // NOTE: this flop array is tiny and must come out of reset at 0, so it is
  // reset; bulk storage arrays would normally be left unreset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) sync_q <= '{default: '0};
    else           sync_q <= sync_d;
  end

  logic sck_s, ss_s, mosi_s;
  assign sck_s  = sync_q[SYNC_STAGES-1][2];
  assign ss_s   = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][0];

  logic sck_prev_q, ss_prev_q;
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  state_e            state_q, state_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              rd_started_q, rd_started_d;
  logic              pend_q, pend_d;

  logic              byte_ready, miso_bit, sr_clr;
  logic [DATA_W-1:0] rx_data;
  logic              cmd_done, stb_start, start_we, wdat_load, miso_en;
  logic              tx_load;
  logic [DATA_W-1:0] tx_load_data;

  spi_shift_reg u_shift (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_i),
    .clr        (sr_clr),
    .sck_rise   (sck_rise),
    .sck_fall   (sck_fall),
    .mosi       (mosi_s),
    .load       (tx_load),
    .load_data  (tx_load_data),
    .miso       (miso_bit),
    .rx_data    (rx_data),
    .byte_ready (byte_ready)
  );

  // A frame may not start while an earlier Wishbone cycle is still running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!ss_s && (ss_fall || pend_q) && !stb_q) state_d = CMD;
      CMD:     if (ss_rise) state_d = IDLE;
               else if (byte_ready) state_d = rx_data[CMD_RW_BIT] ? WR_DATA : RD_REQ;
      RD_REQ:  if (ss_rise) state_d = IDLE;
               else if (byte_ready) state_d = DONE;
               else if (stb_q && wb_ack_i) state_d = RD_DATA;
      RD_DATA: if (ss_rise) state_d = IDLE;
               else if (byte_ready) state_d = DONE;
      WR_DATA: if (ss_rise) state_d = IDLE;
               else if (byte_ready) state_d = WR_REQ;
      WR_REQ:  if (stb_q && wb_ack_i) state_d = DONE;
      DONE:    if (ss_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads preload 0xFF so a late ack still yields a defined byte on MISO;
  // read data is only loaded if no bit of the data byte has gone out yet.
  always_comb begin
    cmd_done     = (state_q == CMD) && (state_d == RD_REQ || state_d == WR_DATA);
    stb_start    = 1'b0;
    start_we     = 1'b0;
    wdat_load    = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = '1;
    if (state_q == CMD && state_d == RD_REQ) begin
      stb_start = 1'b1;
      tx_load   = 1'b1;
    end
    if (state_q == RD_REQ && state_d == RD_DATA && !rd_started_q && !sck_rise) begin
      tx_load      = 1'b1;
      tx_load_data = wb_dat_i;
    end
    if (state_q == WR_DATA && state_d == WR_REQ) begin
      stb_start = 1'b1;
      start_we  = 1'b1;
      wdat_load = 1'b1;
    end
    miso_en = (state_q == RD_REQ) || (state_q == RD_DATA);
    sr_clr  = (state_q == IDLE) || ss_s;
  end

  // The Wishbone cycle lives in its own flops so it can outlast the frame.
  always_comb begin
    stb_d        = stb_start | (stb_q & ~wb_ack_i);
    we_d         = stb_start ? start_we : (we_q & stb_d);
    addr_d       = cmd_done ? cmd_addr(rx_data) : addr_q;
    wdat_d       = wdat_load ? rx_data : wdat_q;
    rd_started_d = (state_q == RD_REQ) && (rd_started_q || sck_rise);
    pend_d       = (state_q == IDLE) && !ss_s && (pend_q || (ss_fall && stb_q));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= IDLE;
      sck_prev_q   <= 1'b0;
      ss_prev_q    <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      rd_started_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_prev_q   <= sck_s;
      ss_prev_q    <= ss_s;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      rd_started_q <= rd_started_d;
      pend_q       <= pend_d;
    end
  end

  assign spi_miso  = miso_bit & miso_en;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = wdat_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl: an SPI master task drives frames while a
// Wishbone responder with configurable ack delay records every strobe cycle.
module tb_spi_ctrl;
  import spi_ctrl_pkg::*;

  localparam int HALF = 4;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b0;
  logic       spi_sck  = 1'b0;
  logic       spi_ss   = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] wb_addr_o, wb_dat_o;
  logic [7:0] wb_dat_i = 8'h00;
  logic       wb_stb_o, wb_we_o, wb_ack_i;

  logic ack_en  = 1'b1;
  int   ack_dly = 0;

  int         n_cyc = 0, cur_len = 0, last_len = 0;
  logic       stb_prev = 1'b0;
  logic       cap_we = 1'b0;
  logic [7:0] cap_addr = 8'h00, cap_dat = 8'h00;

  int n_pass = 0, n_fail = 0, n_total = 0;

  spi_ctrl #(.SYNC_STAGES(2)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .wb_addr_o(wb_addr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_ack_i (wb_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ack_dly = 0 ties ack to stb; otherwise ack rises after ack_dly stb cycles.
  assign wb_ack_i = ack_en && wb_stb_o && (ack_dly == 0 || cur_len > ack_dly);

  always @(negedge wb_clk_i) begin
    stb_prev <= wb_stb_o;
    if (wb_stb_o && !stb_prev) begin
      n_cyc    <= n_cyc + 1;
      cap_we   <= wb_we_o;
      cap_addr <= wb_addr_o;
      cap_dat  <= wb_dat_o;
      cur_len  <= 1;
      last_len <= 1;
    end else if (wb_stb_o) begin
      cur_len  <= cur_len + 1;
      last_len <= cur_len + 1;
    end else begin
      cur_len  <= 0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sck  = 1'b1;
      spi_mosi = d[i];
      clks(HALF);
      r = {r[6:0], spi_miso};
      spi_sck = 1'b0;
      clks(HALF);
    end
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] d,
                       output logic [7:0] r0, output logic [7:0] r1);
    spi_ss = 1'b0;
    clks(HALF);
    spi_bits(c, 8, r0);
    spi_bits(d, 8, r1);
    spi_ss = 1'b1;
    clks(2 * HALF);
  endtask

  logic [7:0] r0, r1;
  int base;

  initial begin
    clks(3);
    check("rst_stb",   32'(wb_stb_o),  32'h0);
    check("rst_we",    32'(wb_we_o),   32'h0);
    check("rst_addr",  32'(wb_addr_o), 32'h0);
    check("rst_dat",   32'(wb_dat_o),  32'h0);
    check("rst_miso",  32'(spi_miso),  32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    wb_rst_i = 1'b1;
    clks(4);

    // Read 0x00, ack tied to stb.
    wb_dat_i = 8'hA5;
    base = n_cyc;
    frame(8'h00, 8'h00, r0, r1);
    check("rd_ncyc",   n_cyc - base,     32'd1);
    check("rd_we",     32'(cap_we),      32'h0);
    check("rd_addr",   32'(cap_addr),    32'h00);
    check("rd_len",    last_len,         32'd1);
    check("rd_miso0",  32'(r0),          32'h00);
    check("rd_miso1",  32'(r1),          32'hA5);
    check("ss_hi_miso", 32'(spi_miso),   32'h0);

    // Write 0xDE to 0x00.
    base = n_cyc;
    frame(8'h80, 8'hDE, r0, r1);
    check("wr_ncyc",   n_cyc - base,     32'd1);
    check("wr_we",     32'(cap_we),      32'h1);
    check("wr_addr",   32'(cap_addr),    32'h00);
    check("wr_dat",    32'(cap_dat),     32'hDE);

    // Write 0x3C to 0x05 with ack three clocks late.
    ack_dly = 3;
    base = n_cyc;
    frame(8'h85, 8'h3C, r0, r1);
    check("dly_ncyc",  n_cyc - base,     32'd1);
    check("dly_len",   last_len,         32'd4);
    check("dly_addr",  32'(cap_addr),    32'h05);
    check("dly_dat",   32'(cap_dat),     32'h3C);
    check("dly_we",    32'(cap_we),      32'h1);

    // Read whose ack arrives after the data byte has started: MISO sends 0xFF.
    ack_dly = 20;
    wb_dat_i = 8'h66;
    base = n_cyc;
    frame(8'h07, 8'h00, r0, r1);
    check("late_ncyc", n_cyc - base,     32'd1);
    check("late_len",  last_len,         32'd21);
    check("late_addr", 32'(cap_addr),    32'h07);
    check("late_miso", 32'(r1),          32'hFF);
    ack_dly = 0;

    // Write aborted four bits into the data byte, then a clean read of 0x01.
    base = n_cyc;
    spi_ss = 1'b0;
    clks(HALF);
    spi_bits(8'h81, 8, r0);
    spi_bits(8'hF0, 4, r1);
    spi_ss = 1'b1;
    clks(3 * HALF);
    check("abort_ncyc",  n_cyc - base,   32'd0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    wb_dat_i = 8'h5A;
    frame(8'h01, 8'h00, r0, r1);
    check("post_ncyc", n_cyc - base,     32'd1);
    check("post_addr", 32'(cap_addr),    32'h01);
    check("post_we",   32'(cap_we),      32'h0);
    check("post_miso", 32'(r1),          32'h5A);

    // Reset while a write waits for ack.
    ack_en = 1'b0;
    spi_ss = 1'b0;
    clks(HALF);
    spi_bits(8'h92, 8, r0);
    spi_bits(8'h77, 8, r1);
    for (int i = 0; i < 50 && !wb_stb_o; i++) clks(1);
    check("wrq_stb",   32'(wb_stb_o),    32'h1);
    check("wrq_state", 32'(dut.state_q), 32'(WR_REQ));
    #2 wb_rst_i = 1'b0;
    #1;
    check("mrst_stb",  32'(wb_stb_o),    32'h0);
    check("mrst_we",   32'(wb_we_o),     32'h0);
    check("mrst_addr", 32'(wb_addr_o),   32'h0);
    check("mrst_dat",  32'(wb_dat_o),    32'h0);
    check("mrst_miso", 32'(spi_miso),    32'h0);
    check("mrst_state", 32'(dut.state_q), 32'(IDLE));
    spi_ss = 1'b1;
    clks(2);
    wb_rst_i = 1'b1;
    ack_en = 1'b1;
    base = n_cyc;
    clks(20);
    check("mrst_nocyc", n_cyc - base,    32'd0);
    check("mrst_stb2",  32'(wb_stb_o),   32'h0);

    // Back-to-back read then write with one SCK period of SS high between.
    base = n_cyc;
    wb_dat_i = 8'h3E;
    frame(8'h03, 8'h00, r0, r1);
    check("b2b_rd_addr", 32'(cap_addr),  32'h03);
    check("b2b_rd_we",   32'(cap_we),    32'h0);
    check("b2b_rd_miso", 32'(r1),        32'h3E);
    frame(8'h84, 8'hC7, r0, r1);
    check("b2b_wr_addr", 32'(cap_addr),  32'h04);
    check("b2b_wr_we",   32'(cap_we),    32'h1);
    check("b2b_wr_dat",  32'(cap_dat),   32'hC7);
    check("b2b_ncyc",    n_cyc - base,   32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
